sprite_rom_arbiter: RTL
=======================

Name: sprite_rom_arbiter

Overview:
- Shares one read-only sprite/glyph image BRAM between NUM_REQ independent pixel-pipeline requesters, such as the background image, alphabet text and popcat sprite renderers.
- Accepts one address per cycle using a valid/ready handshake and arbitrates round-robin.
- Drives the single BRAM port and routes each returned word back to the requester that issued it.
- Sits between the sprite address generators and the shared image ROM, upstream of the per-sprite palette lookups.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 17, ROM address width (131072 entries).
- DATA_WIDTH, 8, ROM word width (palette index).
- ROM_LATENCY, 2, cycles from ROM address sample to valid ROM data (2 = HIGH_PERFORMANCE BRAM, 1 = LOW_LATENCY).

Ports:
- pixel_clk_in  input  1  pixel clock; the only clock.
- rst_n_in  input  1  asynchronous, active-low reset.
- req_valid_in  input  NUM_REQ  per-requester address valid.
- req_addr_in  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_ready_out  output  NUM_REQ  one-hot grant; a transfer occurs when valid and ready are both high.
- rom_addr_out  output  ADDR_WIDTH  registered address to the BRAM addra.
- rom_en_out  output  1  registered read strobe to the BRAM ena.
- rom_data_in  input  DATA_WIDTH  BRAM douta.
- rsp_valid_out  output  NUM_REQ  one-hot; the response belongs to this requester.
- rsp_data_out  output  DATA_WIDTH  returned word; valid only while any rsp_valid_out bit is high.

Behaviour:
- Reset, asynchronous on rst_n_in low:
  - rom_addr_out=0, rom_en_out=0, rsp_valid_out=0, rsp_data_out=0.
  - RR pointer=0; tag pipeline cleared.
  - In-flight responses are discarded and never reported after reset.
  - req_ready_out=0 while rst_n_in is low.
- Arbitration (combinational in cycle T):
  - Search req_valid_in starting at the RR pointer, wrapping modulo NUM_REQ; the first set bit wins.
  - req_ready_out is one-hot on the winner, or 0 when no request is valid.
  - At most one grant per cycle.
- Pointer update: on a grant to requester i, pointer <= (i+1) mod NUM_REQ at the next edge. With no grant the pointer holds.
- Requester rules:
  - Must hold valid and address stable until ready is seen.
  - ready depends on valid, so requesters must not gate valid on ready.
- Issue: on a grant in cycle T, rom_addr_out <= granted address and rom_en_out <= 1, both visible in cycle T+1. With no grant, rom_en_out <= 0 and rom_addr_out holds its last value.
- Tag pipeline:
  - ROM_LATENCY+1 stages, each holding {valid, one-hot requester id}.
  - Stage 0 loads at the grant edge; stages advance every cycle unconditionally. There is no backpressure on responses.
- Response:
  - In cycle T+1+ROM_LATENCY (default T+3), rsp_valid_out = the tag's one-hot id.
  - rsp_data_out is registered from rom_data_in, or passed through when rsp_valid_out is high; both present the same cycle alignment.
  - Fixed handshake-to-response latency: ROM_LATENCY+1 cycles.
- Throughput:
  - One access per cycle sustained; back-to-back grants to the same or different requesters are allowed.
  - With all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- Boundaries:
  - A single active requester is granted every cycle, regardless of pointer position.
  - When the pointer points at an idle requester, the search wraps with no bubble cycle.
  - A requester whose valid drops in the same cycle it is granted is illegal (assertion in the bench).
- Widths: every address is passed through unmodified; no arithmetic on addresses.

Optional Feature:
- Macro: SPRITE_ARB_PRIO0_EN.
- Defined:
  - Requester 0 has strict priority. Whenever req_valid_in[0]=1, it is granted, regardless of the pointer.
  - The remaining requesters share round-robin among themselves; the pointer is updated only on grants to requesters 1..NUM_REQ-1.
  - Use case: the full-screen background renderer must never stall.
- Undefined: all requesters are equal in the round-robin as described above.

Test Plan:
- Single requester: req_valid_in=4'b0100, req_addr_in[2]=17'h0_1234 held 1 cycle.
  - -> req_ready_out=4'b0100 in T; rom_addr_out=17'h01234 and rom_en_out=1 in T+1.
  - -> rsp_valid_out=4'b0100 in T+3, with rsp_data_out equal to the model ROM[0x1234].
- All four valid continuously from reset, addresses 0x10/0x20/0x30/0x40.
  - -> grant order 0,1,2,3,0,1,... one per cycle.
  - -> responses in the same order with matching data, 3 cycles after each grant.
- Requesters 1 and 3 valid while the pointer is at 2 (after a grant to 1).
  - -> requester 3 is granted first, then 1; rom_en_out stays high both cycles with no bubble.
- Reset mid-flight: grant at T, rst_n_in low at T+1 for 1 cycle.
  - -> all outputs are 0 immediately; no rsp_valid_out in T+3; after release the pointer is 0 and requester 0 wins first.
- Idle: req_valid_in=0 for 10 cycles.
  - -> req_ready_out=0 and rom_en_out=0; rom_addr_out holds the last address; pointer unchanged.
- With SPRITE_ARB_PRIO0_EN: requester 0 valid continuously, requester 1 valid.
  - -> requester 0 is granted every cycle and requester 1 starves.
  - -> after req_valid_in[0] drops, requester 1 is granted the next cycle.

Source files
------------

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: round-robin sharing of one sprite/glyph ROM port.
// Build option SPRITE_ARB_PRIO0_EN gives requester 0 strict priority.
module sprite_rom_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 8,
  parameter int ROM_LATENCY = 2
) (
  input  logic                          pixel_clk_in,
  input  logic                          rst_n_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  output logic [ADDR_WIDTH-1:0]         rom_addr_out,
  output logic                          rom_en_out,
  input  logic [DATA_WIDTH-1:0]         rom_data_in,
  output logic [NUM_REQ-1:0]            rsp_valid_out,
  output logic [DATA_WIDTH-1:0]         rsp_data_out
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int NT = ROM_LATENCY + 1;

  logic [PW-1:0]           ptr_q;
  logic [PW-1:0]           ptr_d;
  logic [NUM_REQ-1:0]      rr_vld;
  logic [2*NUM_REQ-1:0]    dbl;
  logic [2*NUM_REQ-1:0]    shf;
  logic [NUM_REQ-1:0]      rot;
  logic [PW-1:0]           off;
  logic [PW:0]             sum;
  logic [PW-1:0]           win;
  logic                    gnt_any;
  logic                    rr_gnt;
  logic [NUM_REQ-1:0]      gnt;
  logic [ADDR_WIDTH-1:0]   gnt_addr;

  logic [ADDR_WIDTH-1:0]   rom_addr_q;
  logic                    rom_en_q;
  logic [NUM_REQ-1:0]      tag_q [NT];
  logic [NT-1:0]           tv_q;

  // Rotate valids so the pointer sits at bit 0, then take the lowest set bit.
  always_comb begin
    rr_vld = req_valid_in;
`ifdef SPRITE_ARB_PRIO0_EN
    rr_vld[0] = 1'b0;
`endif
    dbl = {rr_vld, rr_vld};
    shf = dbl >> ptr_q;
    rot = shf[NUM_REQ-1:0];
    off = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = PW'(k);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (PW+1)'(NUM_REQ)) sum = sum - (PW+1)'(NUM_REQ);
    rr_gnt = |rr_vld;
    win = sum[PW-1:0];
    gnt_any = rr_gnt;
`ifdef SPRITE_ARB_PRIO0_EN
    if (req_valid_in[0]) begin
      win = '0;
      gnt_any = 1'b1;
      rr_gnt = 1'b0;
    end
`endif
  end

  always_comb begin
    gnt = '0;
    if (gnt_any) gnt = NUM_REQ'(1) << win;
    gnt_addr = req_addr_in[win*ADDR_WIDTH +: ADDR_WIDTH];
    ptr_d = ptr_q;
    if (rr_gnt) begin
      if (win == PW'(NUM_REQ - 1)) ptr_d = '0;
      else ptr_d = win + PW'(1);
    end
  end

  assign req_ready_out = rst_n_in ? gnt : '0;

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_q      <= '0;
      rom_addr_q <= '0;
      rom_en_q   <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      rom_en_q <= gnt_any;
      if (gnt_any) rom_addr_q <= gnt_addr;
    end
  end

  // Tags march alongside the ROM read; no backpressure exists.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int k = 0; k < NT; k++) tag_q[k] <= '0;
      tv_q <= '0;
    end else begin
      tag_q[0] <= gnt;
      tv_q[0]  <= gnt_any;
      for (int k = 1; k < NT; k++) begin
        tag_q[k] <= tag_q[k-1];
        tv_q[k]  <= tv_q[k-1];
      end
    end
  end

  assign rom_addr_out  = rom_addr_q;
  assign rom_en_out    = rom_en_q;
  assign rsp_valid_out = tv_q[NT-1] ? tag_q[NT-1] : '0;
  assign rsp_data_out  = (|rsp_valid_out) ? rom_data_in : '0;

endmodule
